// File: rtl/dice_pkg.sv
// -----------------------------------------------------------------------------
// dice_pkg
// Shared definitions for the dice roller. This package holds the die codes, the
// per-die face count N and rejection mask M, the roller state enum, and the
// data widths.
// -----------------------------------------------------------------------------
package dice_pkg;

  localparam int RESULT_W = 7;  // 4 x d20 = 80 fits in 7 bits
  localparam int FACE_W   = 5;  // faces 1..20
  localparam int RAND_W   = 5;  // LFSR word width
  localparam int TRY_W    = 5;  // retry counter; MAX_TRIES-1 <= 30

  localparam logic [2:0] DIE_D4      = 3'd0;
  localparam logic [2:0] DIE_D6      = 3'd1;
  localparam logic [2:0] DIE_D8      = 3'd2;
  localparam logic [2:0] DIE_D10     = 3'd3;
  localparam logic [2:0] DIE_D12     = 3'd4;
  localparam logic [2:0] DIE_D20     = 3'd5;
  localparam logic [2:0] DIE_D2      = 3'd6;
  localparam logic [2:0] DIE_D20_ALT = 3'd7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } state_t;

  // Number of faces N on the die selected by code.
  function automatic logic [FACE_W-1:0] face_count(input logic [2:0] code);
    case (code)
      DIE_D4:  return 5'd4;
      DIE_D6:  return 5'd6;
      DIE_D8:  return 5'd8;
      DIE_D10: return 5'd10;
      DIE_D12: return 5'd12;
      DIE_D2:  return 5'd2;
      default: return 5'd20;  // DIE_D20 and DIE_D20_ALT
    endcase
  endfunction

  // Smallest all-ones mask M covering 0..N-1. Because M < 2N, a rejected
  // sample minus N always lands back inside 0..N-1.
  function automatic logic [RAND_W-1:0] face_mask(input logic [2:0] code);
    case (code)
      DIE_D4:  return 5'd3;
      DIE_D6:  return 5'd7;
      DIE_D8:  return 5'd7;
      DIE_D10: return 5'd15;
      DIE_D12: return 5'd15;
      DIE_D2:  return 5'd1;
      default: return 5'd31;
    endcase
  endfunction

endpackage

// File: rtl/dice_roller_if.sv
// -----------------------------------------------------------------------------
// dice_roller_if
// This interface groups the request and result signals of the dice roller.
//   roll_req     : start request, level-sampled while the roller is idle
//   die_sel      : die code (see dice_pkg)
//   n_dice       : number of dice minus one
//   busy         : roll in progress
//   result_valid : one-cycle pulse when result updates
//   result       : sum of faces, held until the next completed roll
//   last_face    : face of the most recently accepted die
// The master modport is the requester. The slave modport is the roller.
// -----------------------------------------------------------------------------
interface dice_roller_if;

  logic                          roll_req;
  logic [2:0]                    die_sel;
  logic [1:0]                    n_dice;
  logic                          busy;
  logic                          result_valid;
  logic [dice_pkg::RESULT_W-1:0] result;
  logic [dice_pkg::FACE_W-1:0]   last_face;

  modport master (
    output roll_req, die_sel, n_dice,
    input  busy, result_valid, result, last_face
  );

  modport slave (
    input  roll_req, die_sel, n_dice,
    output busy, result_valid, result, last_face
  );

endinterface

// File: rtl/dice_face_map.sv
// -----------------------------------------------------------------------------
// dice_face_map
// This block is a purely combinational rejection-sampling step for one LFSR
// sample.
//   die_code     in  3  latched die code
//   rand_in      in  5  current LFSR word
//   force_accept in  1  retry budget exhausted; fold an out-of-range sample
//   accept       out 1  sample produces a face this cycle
//   face         out 5  accepted face, 1..N (0 when not accepted)
// -----------------------------------------------------------------------------
module dice_face_map
  import dice_pkg::*;
(
  input  logic [2:0]        die_code,
  input  logic [RAND_W-1:0] rand_in,
  input  logic              force_accept,
  output logic              accept,
  output logic [FACE_W-1:0] face
);

  logic [RAND_W-1:0] r;
  logic [FACE_W-1:0] n;

  always_comb begin
    // NOTE: every output gets a default first, so no path can leave one
    // unassigned and infer a latch.
    r      = rand_in & face_mask(die_code);
    n      = face_count(die_code);
    accept = 1'b0;
    face   = '0;
    if (r < n) begin
      accept = 1'b1;
      face   = r + 5'd1;
    end else if (force_accept) begin
      // M < 2N guarantees r - N lies in 0..N-1.
      accept = 1'b1;
      face   = r - n + 5'd1;
    end
  end

endmodule

// File: rtl/dice_roller.sv
// -----------------------------------------------------------------------------
// dice_roller
// This block turns the free-running LFSR stream into fair die rolls and sums
// 1 to 4 dice. It takes one sample per DRAW cycle. A bounded retry count gives
// a fixed worst-case latency of dice*MAX_TRIES+1 cycles.
//   clk      in  1  sole clock, rising edge
//   rst      in  1  synchronous active-high reset
//   rand_in  in  5  LFSR word, new value every cycle
//   bus      slave modport of dice_roller_if (request / result signals)
// Parameter MAX_TRIES (2..31) sets the number of samples per die before
// forced acceptance.
// -----------------------------------------------------------------------------
module dice_roller
  import dice_pkg::*;
#(
  parameter int MAX_TRIES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RAND_W-1:0] rand_in,
  dice_roller_if.slave      bus
);

  state_t              state;
  logic [2:0]          die_q;
  logic [1:0]          dice_left;
  logic [TRY_W-1:0]    tries;
  logic [RESULT_W-1:0] acc;

  logic                force_accept;
  logic                accept;
  logic [FACE_W-1:0]   face;
  logic [RESULT_W-1:0] sum;

  assign force_accept = (tries == TRY_W'(MAX_TRIES - 1));
  assign sum          = acc + RESULT_W'(face);

  dice_face_map u_face_map (
    .die_code     (die_q),
    .rand_in      (rand_in),
    .force_accept (force_accept),
    .accept       (accept),
    .face         (face)
  );

  // NOTE: this block holds state only, so it uses non-blocking assignments.
  // Every register then updates from the values of the previous cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      die_q            <= '0;
      dice_left        <= '0;
      tries            <= '0;
      acc              <= '0;
      bus.busy         <= 1'b0;
      bus.result_valid <= 1'b0;
      bus.result       <= '0;
      bus.last_face    <= '0;
    end else begin
      bus.result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.roll_req) begin
            die_q     <= bus.die_sel;
            dice_left <= bus.n_dice;
            acc       <= '0;
            tries     <= '0;
            bus.busy  <= 1'b1;
            state     <= ST_DRAW;
          end
        end
        ST_DRAW: begin
          if (accept) begin
            bus.last_face <= face;
            tries         <= '0;
            acc           <= sum;
            if (dice_left == 2'd0) begin
              bus.result       <= sum;
              bus.result_valid <= 1'b1;
              bus.busy         <= 1'b0;
              state            <= ST_IDLE;
            end else begin
              dice_left <= dice_left - 2'd1;
            end
          end else begin
            tries <= tries + TRY_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roller.sv
// -----------------------------------------------------------------------------
// tb_dice_roller
// This is a scoreboard bench for dice_roller. The driver works out each roll's
// sum, last face and completion cycle from the die rules, using the exact
// sample stream it is about to drive, and queues the result. A separate
// monitor pops one entry per result_valid pulse and compares. Between pulses
// it checks that result is held.
// -----------------------------------------------------------------------------
module tb_dice_roller;

  localparam int MAX_TRIES = 16;

  typedef struct {
    int result;
    int last_face;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rand_in;
  int         cyc = 0;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  int   stim_q[$];
  int   held_result = 0;
  bit   done = 1'b0;

  dice_roller_if bus ();

  dice_roller #(.MAX_TRIES(MAX_TRIES)) dut (
    .clk     (clk),
    .rst     (rst),
    .rand_in (rand_in),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: faces per die code and the power-of-two-minus-one mask.
  // Each die draws samples until one falls below N. The MAX_TRIES-th sample
  // is folded down by N instead.
  function automatic void model(input int die, input int n, input int vals[$],
                                output int sum, output int last, output int used);
    int n_tab[8] = '{4, 6, 8, 10, 12, 20, 2, 20};
    int m_tab[8] = '{3, 7, 7, 15, 15, 31, 1, 31};
    int idx = 0;
    sum = 0;
    last = 0;
    for (int d = 0; d <= n; d++) begin
      int face = 0;
      for (int t = 1; t <= MAX_TRIES; t++) begin
        int r = vals[idx] & m_tab[die];
        idx++;
        if (r < n_tab[die]) begin
          face = r + 1;
          break;
        end
        if (t == MAX_TRIES) face = r - n_tab[die] + 1;
      end
      sum += face;
      last = face;
    end
    used = idx;
  endfunction

  // This task is entered and exits at #1 after a rising edge. It issues
  // roll_req in the current cycle and drives one sample per DRAW cycle. It
  // returns in the cycle where result_valid is expected. If hold is set,
  // roll_req stays high through DRAW, and the DUT must ignore it there.
  task automatic roll(input int die, input int n, input bit hold);
    int   vals[$];
    int   sum, last, used;
    exp_t e;
    if (stim_q.size() > 0) begin
      vals   = stim_q;
      stim_q = {};
    end else begin
      for (int i = 0; i < (n + 1) * MAX_TRIES; i++) vals.push_back(int'($urandom_range(0, 31)));
    end
    model(die, n, vals, sum, last, used);
    bus.roll_req = 1'b1;
    bus.die_sel  = 3'(die);
    bus.n_dice   = 2'(n);
    rand_in      = 5'($urandom);
    e.result     = sum;
    e.last_face  = last;
    e.cyc        = cyc + used + 1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    for (int i = 0; i < used; i++) begin
      bus.roll_req = hold;
      bus.die_sel  = 3'($urandom);   // must not affect the roll in flight
      bus.n_dice   = 2'($urandom);
      rand_in      = 5'(vals[i]);
      check("busy_in_draw", {31'd0, bus.busy}, 32'd1);
      @(posedge clk); #1;
    end
    bus.roll_req = 1'b0;
    check("busy_after_roll", {31'd0, bus.busy}, 32'd0);
    check("valid_at_end", {31'd0, bus.result_valid}, 32'd1);
  endtask

  task automatic idle(input int cycles);
    bus.roll_req = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      rand_in = 5'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pops on every result_valid pulse and checks that result holds
  // between pulses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!done && rst === 1'b0) begin
        if (bus.result_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("result", 32'(bus.result), 32'(e.result));
            check("last_face", 32'(bus.last_face), 32'(e.last_face));
            check("valid_cycle", 32'(cyc), 32'(e.cyc));
            held_result = e.result;
          end
        end else begin
          check("result_held", 32'(bus.result), 32'(held_result));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.roll_req = 1'b0;
    bus.die_sel  = '0;
    bus.n_dice   = '0;
    rand_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_valid", {31'd0, bus.result_valid}, 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_last_face", 32'(bus.last_face), 32'd0);
    rst = 1'b0;
    idle(2);

    // Single d6 with rejects: 7 and 6 are rejected, 2 gives face 3.
    stim_q = '{7, 6, 2};
    roll(1, 0, 1'b0);
    check("d6_result", 32'(bus.result), 32'd3);
    check("d6_last_face", 32'(bus.last_face), 32'd3);
    idle(2);

    // Four d20 with no rejects: faces 20+1+11+5 = 37.
    stim_q = '{19, 0, 10, 4};
    roll(5, 3, 1'b0);
    check("4d20_result", 32'(bus.result), 32'd37);
    check("4d20_last_face", 32'(bus.last_face), 32'd5);
    idle(1);

    // Forced accept on d10: 15 rejected 15 times, then folded to 15-10+1 = 6.
    for (int i = 0; i < MAX_TRIES; i++) stim_q.push_back(15);
    roll(3, 0, 1'b0);
    check("forced_result", 32'(bus.result), 32'd6);
    idle(1);

    // Code 7 acts as d20: 25 is rejected, and 3 gives face 4.
    stim_q = '{25, 3};
    roll(7, 0, 1'b0);
    check("code7_result", 32'(bus.result), 32'd4);
    idle(1);

    // d2 with 31: 31 & 1 = 1 gives face 2.
    stim_q = '{31};
    roll(6, 0, 1'b0);
    check("d2_result", 32'(bus.result), 32'd2);
    check("d2_last_face", 32'(bus.last_face), 32'd2);
    idle(1);

    // Request held through a d4 roll, followed at once by a second roll.
    roll(0, 1, 1'b1);
    roll(2, 2, 1'b1);
    idle(2);

    // Reset asserted in the second DRAW cycle of a 3-die d6 roll.
    bus.roll_req = 1'b1;
    bus.die_sel  = 3'd1;
    bus.n_dice   = 2'd2;
    @(posedge clk); #1;
    bus.roll_req = 1'b0;
    rand_in      = 5'd2;
    @(posedge clk); #1;
    rand_in = 5'd2;
    rst     = 1'b1;
    @(posedge clk); #1;
    rst         = 1'b0;
    held_result = 0;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_valid", {31'd0, bus.result_valid}, 32'd0);
    check("midrst_result", 32'(bus.result), 32'd0);
    check("midrst_last_face", 32'(bus.last_face), 32'd0);
    check("midrst_state", {31'd0, dut.state}, 32'd0);
    stim_q = '{1, 1, 1};
    roll(1, 2, 1'b0);
    check("post_rst_result", 32'(bus.result), 32'd6);
    idle(1);

    // Randomised rolls: random die, count, request holding and gaps.
    for (int k = 0; k < 40; k++) begin
      roll(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 1'($urandom));
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
    end

    idle(4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dice_roller.md
# dice_roller

Converts the free-running LFSR stream into fair die rolls for the dice project. Sits directly downstream of the LFSR stage: consumes its 5-bit random word every cycle, performs masked rejection sampling per die type, and sums 1–4 dice into a registered result for the display/output stage. A bounded retry count guarantees a fixed worst-case latency.

## Interface
- `MAX_TRIES`, default 16: samples per die before forced acceptance; range 2–31.
- `clk`  in  1  sole clock; all state on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rand_in`  in  5  LFSR word; new value every cycle, no valid qualifier.
- `roll_req`  in  1  start request; level-sampled, honoured only in IDLE.
- `die_sel`  in  3  die code: 0=d4, 1=d6, 2=d8, 3=d10, 4=d12, 5=d20, 6=d2, 7=d20.
- `n_dice`  in  2  number of dice minus one (0 → 1 die, 3 → 4 dice).
- `busy`  out  1  high while in DRAW.
- `result_valid`  out  1  one-cycle pulse when `result` updates.
- `result`  out  7  sum of faces; max 80; held until the next completed roll.
- `last_face`  out  5  face of the most recently accepted die; range 1–20.

## Operation
- States: IDLE, DRAW. Reset → IDLE, with `busy`=0, `result_valid`=0, `result`=0, `last_face`=0, all internal counters 0.
- **IDLE**
  - If `roll_req`=1: latch `die_sel` and `n_dice`, clear the accumulator and retry counter, then go to DRAW.
  - `die_sel`/`n_dice` changes after the latch have no effect until the next roll.
- **DRAW**, each cycle:
  - Per-die face count N and mask M:
    - d2: N=2, M=1
    - d4: N=4, M=3
    - d6: N=6, M=7
    - d8: N=8, M=7
    - d10: N=10, M=15
    - d12: N=12, M=15
    - d20: N=20, M=31
  - Compute `r = rand_in & M`.
  - Accept if `r < N`; the face is `r+1`.
  - Otherwise, if the retry counter = `MAX_TRIES-1`: force-accept with face `r-N+1`. This face is always in 1..N because M < 2N.
  - Otherwise: reject and increment the retry counter.
- **On any accept**
  - Add the face to the 7-bit accumulator; no overflow is possible.
  - Update `last_face` and clear the retry counter.
  - If this was the final die: load `result` with the new sum, pulse `result_valid`, go to IDLE.
  - Otherwise decrement the dice-remaining counter and stay in DRAW.
- `roll_req` in DRAW is ignored; it is not queued.
- `rst` in any state (including mid-roll) forces the reset values on the next edge. The partial sum is discarded.

## Timing
- `roll_req` sampled high in IDLE at edge k → `busy`=1 from cycle k+1.
- Every DRAW cycle consumes exactly one `rand_in` value.
- Final accept in cycle m → `result`, `last_face`, and the `result_valid` pulse all appear in cycle m+1. In that same cycle `busy`=0 and the state is IDLE.
- `roll_req`=1 in cycle m+1 starts a new roll; there is no dead cycle.
- Minimum latency from request to `result_valid` is (dice+1) cycles.
- Maximum latency is (dice × `MAX_TRIES` + 1) cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `dice_pkg` holds:
  - die code localparams;
  - the face-count function N(code) and the mask function M(code);
  - the state enum;
  - the result width constant (7).
- Sub-module `dice_face_map` is purely combinational.
  - Inputs: die code, `rand_in`, force flag.
  - Outputs: accept, face[4:0].
  - `dice_roller` holds only the FSM, counters, and accumulator.

## Test plan
- **Single d6 with rejects:** `die_sel`=1, `n_dice`=0, `roll_req` at cycle 0; `rand_in`=7,6,2 in cycles 1–3.
  - Required: `busy`=1 in cycles 1–3; `result_valid` in cycle 4; `result`=3; `last_face`=3.
- **Four d20, no rejects:** `die_sel`=5, `n_dice`=3; `rand_in`=19,0,10,4.
  - Required: `result_valid` in cycle 5; `result`=37; `last_face`=5.
- **Forced accept:** `die_sel`=3 (d10), `n_dice`=0; `rand_in` held at 15.
  - Required: samples 1–15 rejected, sample 16 forced; `result_valid` in cycle 17; `result`=6.
- **Request during DRAW, and back-to-back rolls:**
  - `roll_req` held high through a d4 roll is ignored while `busy`.
  - A second roll starts in the cycle `result_valid` pulses.
  - The first `result` is held until the second roll completes.
- **Reset mid-roll:** assert `rst` in the second DRAW cycle of a 3-die roll.
  - Required: next cycle all outputs are 0 and the state is IDLE.
  - A following roll produces a correct sum with no leftover partial sum.
- **Code 7 and d2:**
  - `die_sel`=7 behaves identically to d20.
  - `die_sel`=6 with `rand_in`=31 gives face 2, since 31 & 1 = 1.
